// File: rtl/memory_pkg.sv
// Shared encodings for the byte-serial load/store unit: access sizes, FSM states,
// the byte-lane width and the size/alignment helpers.
package memory_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Index of the final byte of an access: 0, 1 or 3.
  function automatic logic [1:0] last_byte(input size_e s);
    case (s)
      SIZE_HALF: last_byte = 2'd1;
      SIZE_WORD: last_byte = 2'd3;
      default:   last_byte = 2'd0;
    endcase
  endfunction

  // Reserved size, or a half/word not aligned to its own size.
  function automatic logic access_err(input size_e s, input logic [1:0] addr_lo);
    access_err = (s == SIZE_RSVD) ||
                 ((s == SIZE_HALF) && addr_lo[0]) ||
                 ((s == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational zero/sign extension of an assembled load result to 32 bits.
module lsu_extend
  import memory_pkg::*;
(
  input  logic [31:0] data_i,
  input  size_e       size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (size_i)
      SIZE_BYTE: data_o = {{(32-BYTE_W){sign_ext_i & data_i[BYTE_W-1]}}, data_i[BYTE_W-1:0]};
      SIZE_HALF: data_o = {{(32-2*BYTE_W){sign_ext_i & data_i[2*BYTE_W-1]}}, data_i[2*BYTE_W-1:0]};
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: splits byte/half/word accesses into single-byte
// transactions on an 8-bit memory port, stalling on memHit, and assembles load data.
module load_store_unit
  import memory_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] memAddress,
  output logic [BYTE_W-1:0] memWriteData,
  output logic              memRead,
  output logic              memWrite,
  input  logic              memHit,
  input  logic [BYTE_W-1:0] memOut
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] merged;
  logic [31:0] extended;

  lsu_extend u_extend (
    .data_i     (merged),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .data_o     (extended)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    merged = rdata_q;
    merged[32'(cnt_q)*BYTE_W +: BYTE_W] = memOut;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          base_d  = addr;
          we_d    = we;
          size_d  = size_e'(size);
          sext_d  = signExt;
          wdata_d = wdata;
          cnt_d   = 2'd0;
          rdata_d = '0;
          if (access_err(size_e'(size), addr[1:0])) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (memHit) begin
          if (!we_q) rdata_d = merged;
          if (cnt_q == last_byte(size_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (!we_q) rdata_d = extended;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Memory port is registered off the next state so strobes align with ACCESS.
    mem_rd_d    = (state_d == ST_ACCESS) && !we_d;
    mem_wr_d    = (state_d == ST_ACCESS) && we_d;
    mem_addr_d  = (state_d == ST_ACCESS) ? base_d + ADDR_W'(cnt_d) : '0;
    mem_wdata_d = (state_d == ST_ACCESS) ? wdata_d[32'(cnt_d)*BYTE_W +: BYTE_W] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign memRead      = mem_rd_q;
  assign memWrite     = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-abort
// sequence and randomized transactions against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req, we, signExt, memHit;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, memAddress;
  logic [7:0]  memWriteData, memOut;
  logic        busy, done, err, memRead, memWrite;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .size         (size),
    .signExt      (signExt),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memHit       (memHit),
    .memOut       (memOut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Little-endian read of the model memory, then extension of the top byte read.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx);
    int n = nbytes(sz);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v |= 32'(mem[8'(a + 32'(i))]) << (8 * i);
    if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  // Issue one request at a negedge and serve it until done, checking every cycle.
  task automatic run_txn(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input int pct,
                         input int stall, input logic exp_err, input logic [31:0] exp_rd);
    int  n, idx, cyc, stall_left;
    bit  got_done, hit;
    n = exp_err ? 0 : nbytes(sz);
    req = 1'b1; we = w; size = sz; signExt = sx; addr = a; wdata = wd; memHit = 1'b0;
    @(negedge clk);
    idx = 0; cyc = 0; got_done = 1'b0; stall_left = stall;
    while (!got_done && cyc < 1000) begin
      cyc++;
      // Garbage on the request side while busy must be ignored.
      req = 1'($urandom_range(0, 1)); we = 1'($urandom); size = 2'($urandom);
      signExt = 1'($urandom); addr = $urandom; wdata = $urandom;
      if (done) begin
        got_done = 1'b1;
        req = 1'b0; memHit = 1'b0;
        check($sformatf("%s err", tag), 32'(err), 32'(exp_err));
        check($sformatf("%s strobes in done", tag), 32'(memRead | memWrite), 32'd0);
        if (!exp_err) check($sformatf("%s rdata", tag), rdata, exp_rd);
      end else begin
        check($sformatf("%s busy", tag), 32'(busy), 32'd1);
        if (memRead || memWrite) begin
          check($sformatf("%s memWrite", tag), 32'(memWrite), 32'(w));
          check($sformatf("%s memRead", tag), 32'(memRead), 32'(!w));
          check($sformatf("%s memAddress[%0d]", tag, idx), memAddress, a + 32'(idx));
          if (w) check($sformatf("%s memWriteData[%0d]", tag, idx), 32'(memWriteData),
                       (wd >> (8 * idx)) & 32'hFF);
          if (stall_left > 0) begin
            hit = 1'b0;
            stall_left--;
          end else begin
            hit = ($urandom_range(1, 100) <= pct);
          end
          memHit = hit;
          memOut = mem[memAddress[7:0]];
          if (hit) begin
            if (w) mem[memAddress[7:0]] = memWriteData;
            idx++;
          end
        end else begin
          check($sformatf("%s strobe while busy", tag), 32'd0, 32'd1);
          memHit = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!got_done) begin
      check($sformatf("%s timeout waiting for done", tag), 32'd0, 32'd1);
    end else begin
      check($sformatf("%s bytes accessed", tag), 32'(idx), 32'(n));
      if (pct == 100)
        check($sformatf("%s latency", tag), 32'(cyc), exp_err ? 32'd1 : 32'(n + 1 + stall));
      @(negedge clk);
      check($sformatf("%s done one cycle", tag), 32'(done), 32'd0);
      check($sformatf("%s idle after done", tag), 32'(busy), 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    int          stall;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"word load 0x10",    1'b0, 2'd2, 1'b0, 32'h10,       32'h0,      0, 1'b0, 32'h4433_2211};
    vecs[1] = '{"byte load sext",    1'b0, 2'd0, 1'b1, 32'h7,        32'h0,      0, 1'b0, 32'hFFFF_FF80};
    vecs[2] = '{"byte load zext",    1'b0, 2'd0, 1'b0, 32'h7,        32'h0,      0, 1'b0, 32'h0000_0080};
    vecs[3] = '{"half store stall",  1'b1, 2'd1, 1'b0, 32'h4,        32'hABCD,   2, 1'b0, 32'h0};
    vecs[4] = '{"word load misalign",1'b0, 2'd2, 1'b0, 32'h2,        32'h0,      0, 1'b1, 32'h0};
    vecs[5] = '{"half misalign",     1'b0, 2'd1, 1'b1, 32'h5,        32'h0,      0, 1'b1, 32'h0};
    vecs[6] = '{"reserved size",     1'b1, 2'd3, 1'b0, 32'h8,        32'h1234,   0, 1'b1, 32'h0};
    vecs[7] = '{"half load sext",    1'b0, 2'd1, 1'b1, 32'h20,       32'h0,      0, 1'b0, 32'hFFFF_9234};
    vecs[8] = '{"word store high",   1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hDEADBEEF, 1, 1'b0, 32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h07] = 8'h80;
    mem[8'h20] = 8'h34; mem[8'h21] = 8'h92;

    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; signExt = 1'b0;
    addr = '0; wdata = '0; memHit = 1'b0; memOut = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset strobes", 32'({memRead, memWrite}), 32'd0);
    check("reset memAddress", memAddress, 32'd0);
    check("reset memWriteData", 32'(memWriteData), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].name, vecs[i].w, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd,
              100, vecs[i].stall, vecs[i].e, vecs[i].rd);

    // Reset during the second byte of a word store abandons it.
    req = 1'b1; we = 1'b1; size = 2'd2; signExt = 1'b0; addr = 32'h40; wdata = 32'h1122_3344;
    memHit = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("abort byte0 addr", memAddress, 32'h40);
    check("abort byte0 data", 32'(memWriteData), 32'h44);
    @(negedge clk);
    check("abort byte1 addr", memAddress, 32'h41);
    check("abort byte1 data", 32'(memWriteData), 32'h33);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; memHit = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort memWrite", 32'(memWrite), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort memAddress", memAddress, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort quiet", 32'({done, memWrite, memRead, busy}), 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      logic        w, sx, e;
      logic [1:0]  sz;
      logic [31:0] a, wd, rd;
      w = 1'($urandom); sz = 2'($urandom); sx = 1'($urandom);
      a = $urandom; wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      e  = model_err(sz, a);
      rd = (w || e) ? 32'd0 : model_load(a, sz, sx);
      run_txn($sformatf("rand%0d", t), w, sz, sx, a, wd, $urandom_range(30, 100),
              $urandom_range(0, 3), e, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the address bus.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port req, input, 1 bit: pipeline access request, sampled only in IDLE.
REQ-005 SHALL have port we, input, 1 bit: 1=store, 0=load.
REQ-006 SHALL have port size, input, 2 bits: 00=byte, 01=half, 10=word, 11=reserved.
REQ-007 SHALL have port signExt, input, 1 bit: sign-extend load result when 1.
REQ-008 SHALL have port addr, input, ADDR_W bits: byte address of the access.
REQ-009 SHALL have port wdata, input, 32 bits: store data, low bytes used.
REQ-010 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: valid with done; misaligned or reserved size.
REQ-013 SHALL have port rdata, output, 32 bits: assembled load result.
REQ-014 SHALL have port memAddress, output, ADDR_W bits: byte address to the 8-bit data memory.
REQ-015 SHALL have port memWriteData, output, 8 bits: byte to write.
REQ-016 SHALL have ports memRead and memWrite, output, 1 bit each: access strobes.
REQ-017 SHALL have port memHit, input, 1 bit: memory completed the current byte this cycle.
REQ-018 SHALL have port memOut, input, 8 bits: byte read from memory.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS, DONE, with a 2-bit byte counter cnt and last = 0, 1 or 3 for byte, half or word.
REQ-020 In IDLE with req=1, SHALL latch addr, we, size, signExt and wdata, clear cnt and rdata, and go to ACCESS; if size=11, or a half has addr[0]=1, or a word has addr[1:0]!=0, SHALL instead go to DONE with err=1 and no memory strobe.
REQ-021 In ACCESS, SHALL drive memAddress=base+cnt, memWriteData=wdata byte cnt (little-endian), and memWrite=we or memRead=!we; both strobes SHALL be 0 in every other state.
REQ-022 In ACCESS with memHit=0, SHALL hold all outputs and cnt unchanged (stall, unbounded).
REQ-023 In ACCESS with memHit=1, SHALL capture memOut into rdata byte cnt on a load; if cnt==last, SHALL go to DONE, else cnt+1.
REQ-024 On entry to DONE on a load, SHALL zero- or sign-extend rdata per signExt from bit 7 (byte) or bit 15 (half).
REQ-025 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE; err is 0 for valid accesses.
REQ-026 rdata SHALL hold its value until the next accepted request; req while busy SHALL be ignored.
REQ-027 Latency with all hits SHALL be (last+1) ACCESS cycles plus 1 DONE cycle after acceptance; an error case SHALL take 1 DONE cycle.
REQ-028 base+cnt SHALL wrap modulo 2^ADDR_W.

Reset
REQ-029 With reset=0 at a rising edge, SHALL enter IDLE with cnt=0, rdata=0, done=0, err=0, busy=0, memRead=0, memWrite=0, memAddress=0, memWriteData=0.
REQ-030 Reset mid-ACCESS SHALL abandon the access on that edge, with no further strobes and no done pulse.

Structure
REQ-031 The size encodings, FSM state encodings and byte-lane width SHALL be defined in a shared package, memory_pkg.
REQ-032 SHALL instantiate exactly one sub-module, lsu_extend, a combinational sign/zero extender, and SHALL otherwise be one flat module.

Verification
REQ-033 Word load at 0x10, memOut=0x11,0x22,0x33,0x44, memHit always 1 -> memAddress 0x10..0x13, done on the 5th cycle after acceptance, rdata=0x44332211.
REQ-034 Byte load at 0x7, signExt=1, memOut=0x80 -> rdata=0xFFFFFF80; the same with signExt=0 -> 0x00000080.
REQ-035 Half store at 0x4, wdata=0xABCD, memHit low 2 cycles on the first byte -> memWrite with 0xCD held 3 cycles, then 0xAB at 0x5, then done.
REQ-036 Word load at 0x2 -> done=1 and err=1 one cycle after acceptance, with memRead never asserted.
REQ-037 Reset=0 during the 2nd byte of a word store -> next cycle IDLE, memWrite=0, and no done pulse.
REQ-038 req=1 while busy -> ignored; the original access completes unchanged.
